// File: rtl/sd_block_arbiter.sv
// ----------------------------------------------------------------------------
// sd_block_arbiter
//   Shares a single hps_io SD block channel between two requesters:
//   port 0 = floppy track loader, port 1 = ProDOS HDD sector engine.
//   A request is a run of consecutive 512-byte blocks (all reads or all
//   writes). The arbiter grants round-robin, sequences the run block by
//   block, routes sd_ack to the owner and stalls the CPU while busy.
//
// Ports
//   clk_sys, reset_n           system clock, async active-low reset
//   req_valid/wr/lba/cnt       per-port request (level, held until req_ready)
//   req_ready/done/err         per-port one-cycle pulses
//   blk_idx, owner, busy       run status (blk_idx = buffer block index)
//   cpu_wait                   stall to the 6502 (equals busy)
//   sd_lba, sd_rd, sd_wr       block request to hps_io
//   sd_ack                     hps_io ack (high during a block transfer)
//   sd_ack_out                 sd_ack gated to the owning port
// ----------------------------------------------------------------------------
module sd_block_arbiter #(
   parameter int CNT_W = 4,
   parameter int TO_W  = 24
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic [1:0]         req_valid,
   input  logic [1:0]         req_wr,
   input  logic [63:0]        req_lba,
   input  logic [2*CNT_W-1:0] req_cnt,
   output logic [1:0]         req_ready,
   output logic [1:0]         req_done,
   output logic [1:0]         req_err,
   output logic [CNT_W-1:0]   blk_idx,
   output logic               owner,
   output logic               busy,
   output logic               cpu_wait,
   output logic [31:0]        sd_lba,
   output logic               sd_rd,
   output logic               sd_wr,
   input  logic               sd_ack,
   output logic [1:0]         sd_ack_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_XFER  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [TO_W-1:0]  TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

   state_t             state_r;
   state_t             state_nxt_s;
   logic               ack_q_r;
   logic               ack_rise_s;
   logic               ack_fall_s;
   logic [TO_W-1:0]    to_cnt_r;
   logic               to_sat_s;
   logic               wr_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               last_r;
   logic               win_s;
   logic               grant_s;
   logic               last_blk_s;
   logic [CNT_W-1:0]   win_cnt_s;
   logic [31:0]        win_lba_s;

   // One-hot select of a port
   function automatic logic [1:0] port_bit(input logic p);
      port_bit = p ? 2'b10 : 2'b01;
   endfunction

   assign ack_rise_s = sd_ack & ~ack_q_r;
   assign ack_fall_s = ~sd_ack & ack_q_r;
   assign to_sat_s   = &to_cnt_r;
   assign last_blk_s = (blk_idx == (cnt_r - CNT_ONE));
   assign win_cnt_s  = win_s ? req_cnt[2*CNT_W-1:CNT_W] : req_cnt[CNT_W-1:0];
   assign win_lba_s  = win_s ? req_lba[63:32] : req_lba[31:0];
   assign cpu_wait   = busy;
   // busy drops asynchronously on reset, so the ack gate closes at once too
   assign sd_ack_out = busy ? (port_bit(owner) & {2{sd_ack}}) : 2'b00;

   // State register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Round-robin winner selection and next-state decode
   always_comb begin
      state_nxt_s = state_r;
      grant_s     = 1'b0;
      win_s       = 1'b0;
      // on a tie the port that did not own the last run wins
      if (req_valid == 2'b11) begin
         win_s = ~last_r;
      end else if (req_valid[1]) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
      case (state_r)
         ST_IDLE: begin
            if (|req_valid) begin
               grant_s     = 1'b1;
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (to_sat_s) begin
               state_nxt_s = ST_IDLE;
            end else if (ack_rise_s) begin
               state_nxt_s = ST_XFER;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_XFER: begin
            if (to_sat_s) begin
               state_nxt_s = ST_IDLE;
            end else if (ack_fall_s) begin
               state_nxt_s = last_blk_s ? ST_IDLE : ST_ISSUE;
            end else begin
               state_nxt_s = ST_XFER;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Owner context, block sequencing, timeout and registered outputs
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         ack_q_r   <= 1'b0;
         to_cnt_r  <= '0;
         wr_r      <= 1'b0;
         cnt_r     <= '0;
         last_r    <= 1'b1;
         req_ready <= 2'b00;
         req_done  <= 2'b00;
         req_err   <= 2'b00;
         blk_idx   <= '0;
         owner     <= 1'b0;
         busy      <= 1'b0;
         sd_lba    <= 32'h0000_0000;
         sd_rd     <= 1'b0;
         sd_wr     <= 1'b0;
      end else begin
         ack_q_r   <= sd_ack;
         req_ready <= 2'b00;
         req_done  <= 2'b00;
         req_err   <= 2'b00;
         case (state_r)
            ST_IDLE: begin
               sd_rd <= 1'b0;
               sd_wr <= 1'b0;
               if (grant_s) begin
                  req_ready <= port_bit(win_s);
                  owner     <= win_s;
                  last_r    <= win_s;
                  sd_lba    <= win_lba_s;
                  wr_r      <= req_wr[win_s];
                  cnt_r     <= (win_cnt_s == '0) ? CNT_ONE : win_cnt_s;
                  blk_idx   <= '0;
                  to_cnt_r  <= '0;
                  busy      <= 1'b1;
               end else begin
                  busy      <= 1'b0;
               end
            end
            ST_ISSUE: begin
               if (to_sat_s) begin
                  sd_rd   <= 1'b0;
                  sd_wr   <= 1'b0;
                  req_err <= port_bit(owner);
                  busy    <= 1'b0;
               end else begin
                  to_cnt_r <= to_cnt_r + TO_ONE;
                  // request is held until hps_io starts the transfer
                  if (ack_rise_s) begin
                     sd_rd <= 1'b0;
                     sd_wr <= 1'b0;
                  end else begin
                     sd_rd <= ~wr_r;
                     sd_wr <= wr_r;
                  end
               end
            end
            ST_XFER: begin
               if (to_sat_s) begin
                  sd_rd   <= 1'b0;
                  sd_wr   <= 1'b0;
                  req_err <= port_bit(owner);
                  busy    <= 1'b0;
               end else if (ack_fall_s) begin
                  if (last_blk_s) begin
                     req_done <= port_bit(owner);
                     busy     <= 1'b0;
                  end else begin
                     // re-issue immediately so the next block starts one cycle after the ack edge
                     blk_idx  <= blk_idx + CNT_ONE;
                     sd_lba   <= sd_lba + 32'd1;
                     to_cnt_r <= '0;
                     sd_rd    <= ~wr_r;
                     sd_wr    <= wr_r;
                  end
               end else begin
                  to_cnt_r <= to_cnt_r + TO_ONE;
               end
            end
            default: begin
               sd_rd <= 1'b0;
               sd_wr <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sd_block_arbiter
//   Scoreboard bench: each posted request pushes its expected grant, block
//   sequence and end pulse; a host model serving sd_rd/sd_wr and a monitor
//   on req_ready/req_done/req_err pop and compare them.
// ----------------------------------------------------------------------------
module tb_sd_block_arbiter;

   typedef struct {
      logic [31:0] lba;
      logic        wr;
      logic        own;
      logic [3:0]  idx;
   } blk_t;

   typedef struct {
      logic        wr;
      logic [31:0] lba;
      logic [3:0]  cnt;
   } rq_t;

   logic        clk_sys;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_wr;
   logic [63:0] req_lba;
   logic [7:0]  req_cnt;
   logic [1:0]  req_ready;
   logic [1:0]  req_done;
   logic [1:0]  req_err;
   logic [3:0]  blk_idx;
   logic        owner;
   logic        busy;
   logic        cpu_wait;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;
   logic [1:0]  sd_ack_out;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic        host_en;

   blk_t        exp_blk_q[$];
   logic [1:0]  exp_grant_q[$];
   logic [3:0]  exp_end_q[$];
   rq_t         pend0_q[$];
   rq_t         pend1_q[$];
   int          rdy_cyc_q[$];
   int          end_cyc_q[$];

   sd_block_arbiter #(.CNT_W(4), .TO_W(4)) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_wr     (req_wr),
      .req_lba    (req_lba),
      .req_cnt    (req_cnt),
      .req_ready  (req_ready),
      .req_done   (req_done),
      .req_err    (req_err),
      .blk_idx    (blk_idx),
      .owner      (owner),
      .busy       (busy),
      .cpu_wait   (cpu_wait),
      .sd_lba     (sd_lba),
      .sd_rd      (sd_rd),
      .sd_wr      (sd_wr),
      .sd_ack     (sd_ack),
      .sd_ack_out (sd_ack_out)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive(input int p, input rq_t r);
      if (p == 0) begin
         req_wr[0]      = r.wr;
         req_lba[31:0]  = r.lba;
         req_cnt[3:0]   = r.cnt;
         req_valid[0]   = 1'b1;
      end else begin
         req_wr[1]      = r.wr;
         req_lba[63:32] = r.lba;
         req_cnt[7:4]   = r.cnt;
         req_valid[1]   = 1'b1;
      end
   endtask

   // Queue a request on port p; nblk blocks are expected to be served,
   // end_code = {err,done} pulse expected at the end (0 = none).
   task automatic post(input int p, input logic wr, input logic [31:0] lba,
                       input logic [3:0] cnt, input int nblk, input logic [3:0] end_code);
      rq_t  r;
      blk_t b;
      r.wr = wr; r.lba = lba; r.cnt = cnt;
      if (p == 0) pend0_q.push_back(r); else pend1_q.push_back(r);
      exp_grant_q.push_back((p == 0) ? 2'b01 : 2'b10);
      for (int k = 0; k < nblk; k++) begin
         b.lba = lba + k;
         b.wr  = wr;
         b.own = (p == 1);
         b.idx = 4'(k);
         exp_blk_q.push_back(b);
      end
      if (end_code != 4'b0000) exp_end_q.push_back(end_code);
      if (!req_valid[p]) drive(p, r);
   endtask

   task automatic wait_idle(input int budget);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_sys);
         if (!busy && req_valid == 2'b00 && exp_end_q.size() == 0 &&
             exp_blk_q.size() == 0 && !sd_ack) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_reached", ok, 1'b1);
   endtask

   // Requester side: grant and end pulses against the scoreboard
   always @(negedge clk_sys) begin
      if (reset_n) begin
         if (req_ready != 2'b00) begin
            rdy_cyc_q.push_back(cyc);
            if (exp_grant_q.size() == 0) chk("grant_unexpected", req_ready, 2'b00);
            else chk("grant_port", req_ready, exp_grant_q.pop_front());
            if (req_ready[0]) begin
               if (pend0_q.size() > 0) void'(pend0_q.pop_front());
               if (pend0_q.size() > 0) drive(0, pend0_q[0]); else req_valid[0] = 1'b0;
            end
            if (req_ready[1]) begin
               if (pend1_q.size() > 0) void'(pend1_q.pop_front());
               if (pend1_q.size() > 0) drive(1, pend1_q[0]); else req_valid[1] = 1'b0;
            end
         end
         if ((req_done | req_err) != 2'b00) begin
            end_cyc_q.push_back(cyc);
            if (exp_end_q.size() == 0) chk("end_unexpected", {req_err, req_done}, 4'b0000);
            else chk("run_end", {req_err, req_done}, exp_end_q.pop_front());
         end
      end
   end

   // hps_io model: one-cycle response delay, ack held for 4 cycles
   initial begin
      blk_t b;
      sd_ack = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (host_en && reset_n && (sd_rd || sd_wr) && !sd_ack) begin
            if (exp_blk_q.size() == 0) begin
               chk("blk_unexpected", {sd_rd, sd_wr}, 2'b00);
            end else begin
               b = exp_blk_q.pop_front();
               chk("blk_lba", sd_lba, b.lba);
               chk("blk_dir", {sd_wr, sd_rd}, b.wr ? 2'b10 : 2'b01);
               chk("blk_owner", owner, b.own);
               chk("blk_idx", blk_idx, b.idx);
               chk("blk_cpu_wait", cpu_wait, 1'b1);
               @(negedge clk_sys);
               sd_ack = 1'b1;
               repeat (2) @(negedge clk_sys);
               chk("ack_route", sd_ack_out, b.own ? 2'b10 : 2'b01);
               repeat (2) @(negedge clk_sys);
               sd_ack = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   gap;
      int   hi;
      logic seen;
      reset_n   = 1'b0;
      req_valid = 2'b00;
      req_wr    = 2'b00;
      req_lba   = 64'h0;
      req_cnt   = 8'h00;
      host_en   = 1'b1;
      repeat (3) @(negedge clk_sys);
      chk("rst_ctl", {sd_rd, sd_wr, busy, cpu_wait, owner}, 5'b00000);
      chk("rst_lba", sd_lba, 32'h0);
      chk("rst_pulses", {req_ready, req_done, req_err}, 6'b000000);
      chk("rst_blk_idx", blk_idx, 4'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      // Tie out of reset, then continuous contention: 0,1,0,1
      #1;
      rdy_cyc_q.delete(); end_cyc_q.delete();
      post(0, 1'b0, 32'h10, 4'd1, 1, 4'b0001);
      post(1, 1'b0, 32'h20, 4'd1, 1, 4'b0010);
      post(0, 1'b0, 32'h30, 4'd2, 2, 4'b0001);
      post(1, 1'b0, 32'h40, 4'd1, 1, 4'b0010);
      wait_idle(2000);
      gap = (rdy_cyc_q.size() > 1 && end_cyc_q.size() > 0) ? (rdy_cyc_q[1] - end_cyc_q[0]) : -1;
      chk("rr_gap", gap, 1);

      // Floppy track: 13 reads from LBA 26
      @(negedge clk_sys); #1;
      post(0, 1'b0, 32'd26, 4'd13, 13, 4'b0001);
      wait_idle(2000);

      // Write run across the 32-bit LBA wrap
      @(negedge clk_sys); #1;
      post(1, 1'b1, 32'hFFFF_FFFF, 4'd2, 2, 4'b0010);
      wait_idle(1000);

      // Ack never arrives: timeout after 15 cycles of sd_rd
      host_en = 1'b0;
      @(negedge clk_sys); #1;
      post(0, 1'b0, 32'd100, 4'd1, 0, 4'b0100);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_sys);
         if (sd_rd) begin seen = 1'b1; break; end
      end
      chk("to_issue", seen, 1'b1);
      hi = 0;
      for (int i = 0; i < 40; i++) begin
         if (!sd_rd) break;
         hi++;
         @(negedge clk_sys);
      end
      chk("to_rd_cycles", hi, 15);
      chk("to_err_pulse", req_err, 2'b01);
      wait_idle(100);

      // Stray ack while idle is ignored
      #1 sd_ack = 1'b1;
      repeat (3) @(negedge clk_sys);
      chk("stray_ack_out", sd_ack_out, 2'b00);
      chk("stray_busy", {busy, sd_rd, sd_wr}, 3'b000);
      sd_ack = 1'b0;
      repeat (2) @(negedge clk_sys);
      host_en = 1'b1;

      // Reset during XFER of block 5
      #1;
      post(0, 1'b0, 32'd200, 4'd10, 6, 4'b0000);
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_sys);
         if (busy && blk_idx == 4'd5 && sd_ack && !sd_rd) begin seen = 1'b1; break; end
      end
      chk("mid_reach_blk5", seen, 1'b1);
      @(negedge clk_sys);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_ctl", {sd_rd, sd_wr, busy, cpu_wait, owner}, 5'b00000);
      chk("mid_rst_lba", sd_lba, 32'h0);
      chk("mid_rst_pulses", {req_ready, req_done, req_err}, 6'b000000);
      chk("mid_rst_idx_ack", {blk_idx, sd_ack_out}, 6'b000000);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_sys);
         if (!sd_ack) break;
      end
      reset_n = 1'b1;
      chk("mid_blocks_left", exp_blk_q.size(), 0);
      @(negedge clk_sys); #1;
      post(0, 1'b1, 32'd300, 4'd2, 2, 4'b0001);
      wait_idle(1000);

      // cnt=0 behaves as a single block
      @(negedge clk_sys); #1;
      post(1, 1'b0, 32'd500, 4'd0, 1, 4'b0010);
      wait_idle(1000);
      repeat (20) @(negedge clk_sys);
      chk("final_queues", exp_blk_q.size() + exp_end_q.size() + exp_grant_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
